// File: rtl/spi_miner_pkg.sv
// Shared sizes and field layout for the host-to-miner SPI work frame.
`timescale 1ns/1ps
package spi_miner_pkg;

  localparam int unsigned RX_BITS  = 384;
  localparam int unsigned TX_BITS  = 256;
  localparam int unsigned CNT_W    = $clog2(RX_BITS + 1);
  localparam int unsigned TX_IDX_W = $clog2(TX_BITS);

  // Field offsets inside rx_data
  localparam int unsigned MIDSTATE_MSB = 383;
  localparam int unsigned MIDSTATE_LSB = 128;
  localparam int unsigned BLK2_MSB     = 127;
  localparam int unsigned BLK2_LSB     = 0;

  // Constants shared with sha256_wrapper
  localparam int unsigned MIDSTATE_W  = MIDSTATE_MSB - MIDSTATE_LSB + 1;
  localparam int unsigned BLK2_W      = BLK2_MSB - BLK2_LSB + 1;
  localparam int unsigned SHA_WORD_W  = 32;
  localparam int unsigned SHA_STATE_N = MIDSTATE_W / SHA_WORD_W;

  typedef struct packed {
    logic [MIDSTATE_W-1:0] midstate;
    logic [BLK2_W-1:0]     blk2_head;
  } work_frame_t;

  // Reinterpret a raw received frame as its two fields
  function automatic work_frame_t to_work_frame(input logic [RX_BITS-1:0] raw);
    return work_frame_t'(raw);
  endfunction

endpackage

// File: rtl/spi_slave_link.sv
// SPI mode-0 slave: receives one 384-bit work frame, returns a 256-bit result MSB first.
`timescale 1ns/1ps
module spi_slave_link
  import spi_miner_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               chip_enable,
  input  logic               mosi_bit,
  output logic               miso_bit,
  input  logic [TX_BITS-1:0] tx_data,
  output logic [RX_BITS-1:0] rx_data,
  output logic               rx_valid,
  output logic [CNT_W-1:0]   bit_count
);

  localparam logic [CNT_W-1:0] RX_FULL = CNT_W'(RX_BITS);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_BITS - 1);
  localparam logic [CNT_W-1:0] TX_END  = CNT_W'(TX_BITS);
  localparam logic [CNT_W-1:0] TX_TOP  = CNT_W'(TX_BITS - 1);

  // The top bit of a full shift would never be read: the last bit goes straight into rx_data.
  logic [RX_BITS-2:0]  shift_q;
  logic [CNT_W-1:0]    tx_idx;
  logic [TX_IDX_W-1:0] tx_pos;

  // RX shift register and saturating bit counter; any deselect abandons the frame
  always_ff @(posedge clk or posedge rst or posedge chip_enable) begin
    if (rst || chip_enable) begin
      shift_q   <= '0;
      bit_count <= '0;
    end else if (bit_count < RX_FULL) begin
      shift_q   <= {shift_q[RX_BITS-3:0], mosi_bit};
      bit_count <= bit_count + CNT_W'(1);
    end
  end

  // Frame output: invalidated on the first bit, published on the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (!chip_enable && (bit_count < RX_FULL)) begin
      if (bit_count == '0) begin
        rx_valid <= 1'b0;
      end
      if (bit_count == RX_LAST) begin
        rx_data  <= {shift_q, mosi_bit};
        rx_valid <= 1'b1;
      end
    end
  end

  // TX index follows the bit counter on the falling edge so miso settles before the host samples
  always_ff @(negedge clk or posedge rst or posedge chip_enable) begin
    if (rst || chip_enable) begin
      tx_idx <= '0;
    end else begin
      tx_idx <= bit_count;
    end
  end

  assign tx_pos = TX_IDX_W'(TX_TOP - tx_idx);

  // Output mux: zero when unselected, in reset, or past the end of the result word
  always_comb begin
    miso_bit = 1'b0;
    if (!rst && !chip_enable && (tx_idx < TX_END)) begin
      miso_bit = tx_data[tx_pos];
    end
  end

endmodule

// File: tb/tb_spi_slave_link.sv
// Bench for spi_slave_link: frame-level reference model plus literal spot checks.
`timescale 1ns/1ps
module tb_spi_slave_link;
  import spi_miner_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               chip_enable = 1'b1;
  logic               mosi_bit = 1'b0;
  logic               miso_bit;
  logic [TX_BITS-1:0] tx_data = '0;
  logic [RX_BITS-1:0] rx_data;
  logic               rx_valid;
  logic [CNT_W-1:0]   bit_count;

  spi_slave_link dut (
    .clk         (clk),
    .rst         (rst),
    .chip_enable (chip_enable),
    .mosi_bit    (mosi_bit),
    .miso_bit    (miso_bit),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .bit_count   (bit_count)
  );

  localparam logic [RX_BITS-1:0] SEQ_FRAME =
    384'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f_20212223_24252627_28292a2b_2c2d2e2f;
  localparam logic [TX_BITS-1:0] A5_WORD = {32{8'hA5}};

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the current frame plus the last published frame
  bit                 sent[$];
  logic [RX_BITS-1:0] prev_data  = '0;
  bit                 prev_valid = 1'b0;
  logic [TX_BITS-1:0] cap;
  int                 cap_n;

  function automatic int m_count();
    return (sent.size() > RX_BITS) ? RX_BITS : sent.size();
  endfunction

  function automatic logic [RX_BITS-1:0] m_data();
    logic [RX_BITS-1:0] d;
    if (sent.size() < RX_BITS) return prev_data;
    d = '0;
    for (int i = 0; i < RX_BITS; i++) d = {d[RX_BITS-2:0], sent[i]};
    return d;
  endfunction

  function automatic bit m_valid();
    if (sent.size() == 0) return prev_valid;
    return sent.size() >= RX_BITS;
  endfunction

  // Bit on miso after the falling edge that follows the last rising edge
  function automatic bit m_miso();
    int k;
    if (rst || chip_enable) return 1'b0;
    k = m_count();
    return (k < TX_BITS) ? tx_data[TX_BITS-1-k] : 1'b0;
  endfunction

  task automatic chk(input string name, input logic [RX_BITS-1:0] act, input logic [RX_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    chk({tag, " bit_count"}, RX_BITS'(bit_count), RX_BITS'(m_count()));
    chk({tag, " rx_valid"},  RX_BITS'(rx_valid),  RX_BITS'(m_valid()));
    chk({tag, " rx_data"},   rx_data,             m_data());
  endtask

  task automatic check_miso(input string tag);
    chk({tag, " miso_bit"}, RX_BITS'(miso_bit), RX_BITS'(m_miso()));
  endtask

  task automatic send_bit(input bit b);
    mosi_bit = b;
    #1;
    if (cap_n < TX_BITS) cap[TX_BITS-1-cap_n] = miso_bit;
    cap_n++;
    #3 clk = 1'b1;
    sent.push_back(b);
    #1 check_rx("rise");
    #4 clk = 1'b0;
    #1 check_miso("fall");
  endtask

  task automatic select();
    chip_enable = 1'b0;
    cap_n = 0;
    #2 check_miso("select");
  endtask

  task automatic deselect();
    #2 chip_enable = 1'b1;
    prev_data  = m_data();
    prev_valid = m_valid();
    sent.delete();
    #1 check_rx("deselect");
    check_miso("deselect");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    sent.delete();
    prev_data  = '0;
    prev_valid = 1'b0;
    check_rx("reset");
    check_miso("reset");
    #2 rst = 1'b0;
    #1;
  endtask

  task automatic rand_tx();
    for (int w = 0; w < TX_BITS / 32; w++) tx_data[w*32 +: 32] = $urandom;
  endtask

  task automatic rand_frame(input int n);
    select();
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  initial begin
    // Reset while deselected
    do_reset();
    chk("reset lit rx_data", rx_data, '0);
    chk("reset lit bit_count", RX_BITS'(bit_count), '0);

    // Full frame of bytes 0x00..0x2F with an A5 result word
    tx_data = A5_WORD;
    select();
    chk("first miso lit", RX_BITS'(miso_bit), RX_BITS'(1));
    for (int i = 0; i < RX_BITS; i++) begin
      logic [7:0] byte_v;
      byte_v = 8'(i / 8);
      send_bit(byte_v[7 - (i % 8)]);
    end
    chk("full lit rx_valid", RX_BITS'(rx_valid), RX_BITS'(1));
    chk("full lit bit_count", RX_BITS'(bit_count), RX_BITS'(384));
    chk("full lit rx_data", rx_data, SEQ_FRAME);
    chk("tx lit captured", RX_BITS'(cap), RX_BITS'(A5_WORD));
    deselect();
    chk("hold lit rx_data", rx_data, SEQ_FRAME);
    chk("hold lit rx_valid", RX_BITS'(rx_valid), RX_BITS'(1));

    // Short frame discards its bits
    rand_tx();
    rand_frame(100);
    deselect();
    chk("short lit rx_valid", RX_BITS'(rx_valid), RX_BITS'(0));
    chk("short lit rx_data", rx_data, SEQ_FRAME);

    // Over-long frame keeps only the first 384 bits
    rand_tx();
    rand_frame(400);
    chk("long lit bit_count", RX_BITS'(bit_count), RX_BITS'(384));
    deselect();

    // Reset in mid-frame, then a clean frame
    rand_tx();
    rand_frame(200);
    do_reset();
    chk("midrst lit rx_valid", RX_BITS'(rx_valid), RX_BITS'(0));
    deselect();
    rand_tx();
    rand_frame(RX_BITS);
    chk("after rst lit rx_valid", RX_BITS'(rx_valid), RX_BITS'(1));
    deselect();

    // Random frames of mixed lengths
    for (int f = 0; f < 20; f++) begin
      rand_tx();
      rand_frame(($urandom_range(0, 2) == 0) ? RX_BITS : $urandom_range(1, 399));
      deselect();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
